// File: rtl/prog_sequencer.sv
// prog_sequencer: launches NPROG programs back to back and times each one by its Ack.
// A program that never acknowledges is aborted after TIMEOUT run cycles.
module prog_sequencer #(
    parameter  int          NPROG   = 3,
    parameter  int          CW      = 16,
    parameter  int unsigned TIMEOUT = 16'hFFFF,
    localparam int          IW      = (NPROG > 1) ? $clog2(NPROG) : 1
) (
    input  logic          Clk,
    input  logic          Reset,
    input  logic          Go,
    input  logic          Ack,
    output logic          Start,
    output logic [IW-1:0] ProgIdx,
    output logic [CW-1:0] CycleCt,
    output logic          CycleVld,
    output logic          Timeout,
    output logic          Done,
    output logic          Busy
);
    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, RECORD, DONE} state_t;

    state_t        r_state, w_nxt;
    logic [CW-1:0] r_cnt, w_cnt, w_k, r_ct, w_ct;
    logic [IW-1:0] r_idx, w_idx;
    logic          r_to, w_to, w_abort;
    logic          r_start, r_vld, r_done, r_busy;

    assign w_k = r_cnt + CW'(1);

    always_comb begin
        w_nxt   = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_ct    = r_ct;
        w_to    = r_to;
        w_abort = 1'b0;
        case (r_state)
            IDLE: if (Go) begin
                w_nxt = LAUNCH;
                w_idx = '0;
            end
            LAUNCH: begin
                w_nxt = RUN;
                w_cnt = '0;
            end
            // Ack on the first run cycle may be left over from the previous halt
            RUN: if (Ack && r_cnt != '0) begin
                w_nxt = RECORD;
                w_ct  = w_k;
            end else if (w_k == CW'(TIMEOUT)) begin
                w_nxt   = DONE;
                w_ct    = CW'(TIMEOUT);
                w_to    = 1'b1;
                w_abort = 1'b1;
            end else begin
                w_cnt = w_k;
            end
            RECORD: if (r_idx == IW'(NPROG - 1)) begin
                w_nxt = DONE;
            end else begin
                w_nxt = LAUNCH;
                w_idx = r_idx + IW'(1);
            end
            DONE: if (Go) begin
                w_nxt = LAUNCH;
                w_idx = '0;
                w_to  = 1'b0;
            end
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_ct    <= '0;
            r_to    <= 1'b0;
            r_start <= 1'b0;
            r_vld   <= 1'b0;
            r_done  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_ct    <= w_ct;
            r_to    <= w_to;
            r_start <= (w_nxt == LAUNCH);
            r_vld   <= (w_nxt == RECORD) || w_abort;
            r_done  <= (w_nxt == DONE);
            r_busy  <= (w_nxt inside {LAUNCH, RUN, RECORD});
        end
    end

    assign Start    = r_start;
    assign ProgIdx  = r_idx;
    assign CycleCt  = r_ct;
    assign CycleVld = r_vld;
    assign Timeout  = r_to;
    assign Done     = r_done;
    assign Busy     = r_busy;
endmodule

// File: doc/prog_sequencer.md
# prog_sequencer

Run controller that sits directly upstream of the processor top level. It drives the processor's `Start` and observes its `Ack` done flag. It launches `NPROG` programs back to back and measures the cycle count of each one. Each per-program count is published with a one-cycle valid strobe, and a stuck program is aborted by a timeout.

## Interface
- `NPROG`, default 3: number of programs per run; must be ≥1.
- `CW`, default 16: cycle-counter width.
- `TIMEOUT`, default 16'hFFFF: maximum RUN cycles per program; must satisfy 2 ≤ `TIMEOUT` ≤ 2^CW−1.
- `IW`, derived: `IW = (NPROG>1) ? $clog2(NPROG) : 1`.

- `Clk`, input, 1: sole clock, posedge.
- `Reset`, input, 1: asynchronous, active-low reset.
- `Go`, input, 1: run request, sampled at posedge.
- `Ack`, input, 1: processor done flag; level, may be stale.
- `Start`, output, 1: processor start pulse.
- `ProgIdx`, output, IW: index of the current or just-finished program.
- `CycleCt`, output, CW: latched cycle count of the last finished program.
- `CycleVld`, output, 1: one-cycle strobe; `CycleCt`/`ProgIdx` valid.
- `Timeout`, output, 1: sticky; the last run was aborted.
- `Done`, output, 1: run complete, level.
- `Busy`, output, 1: high in LAUNCH, RUN and RECORD.

## Operation
- All outputs are registered.
- States are IDLE, LAUNCH, RUN, RECORD and DONE.
- **IDLE**
  - `Go`=1 → LAUNCH, with `ProgIdx`←0.
- **LAUNCH**
  - `Start`=1 for exactly this one cycle.
  - The internal count `cnt` is cleared to 0.
  - Unconditionally → RUN.
- **RUN**
  - `cnt` increments each cycle. The current RUN cycle number is k = cnt+1.
  - k=1: `Ack` is ignored, because it may still be high from the previous halt.
  - k≥2 and `Ack`=1 → RECORD, with `CycleCt`←k.
  - k=`TIMEOUT` and `Ack`=0 → DONE, with `CycleCt`←`TIMEOUT`, `Timeout`←1 and a `CycleVld` pulse; the run is aborted.
  - If `Ack`=1 on the k=`TIMEOUT` cycle, `Ack` wins and this is a normal finish.
- **RECORD**
  - `CycleVld`=1, with `ProgIdx` still equal to the finished program.
  - If `ProgIdx`=NPROG−1 → DONE.
  - Otherwise `ProgIdx`←`ProgIdx`+1 → LAUNCH.
- **DONE**
  - `Done`=1; `ProgIdx` and `CycleCt` hold.
  - `Go`=1 → LAUNCH, clearing `Done` and `Timeout` and setting `ProgIdx`←0.
- `Go` is ignored while `Busy`=1.
- `cnt` cannot exceed `TIMEOUT`, so it never wraps.
- `ProgIdx` never exceeds NPROG−1.

## Timing
- **Reset values** (asserted asynchronously, immediately, including mid-run): state IDLE; `Start`, `ProgIdx`, `CycleCt`, `CycleVld`, `Timeout`, `Done`, `Busy` and `cnt` all 0.
- **Deassertion**: the first active edge after `Reset` rises is a normal IDLE edge.
- **Start latency**: `Go` sampled at edge n → `Start`=1 and `Busy`=1 during cycle n+1. `Start` is low from cycle n+2, the first RUN cycle.
- **Finish latency**: `Ack` sampled high at RUN cycle k → `CycleVld`=1 in the following cycle (RECORD).
- **Next launch**: the next program's `Start` comes one cycle after RECORD.
- **Per-program cost**: k + 2 cycles, plus one cycle from the final RECORD to `Done`.
- **Timeout abort**: `CycleVld`, `Timeout` and `Done` rise together in the cycle after RUN cycle `TIMEOUT`; `Busy` falls in that same cycle.
- **Strobe and flag shapes**: `CycleVld` is never high for two consecutive cycles; `Start` is never high for two consecutive cycles.
- **Simultaneous events**:
  - `Go` in DONE while `Ack` is high: `Ack` is irrelevant outside RUN.
  - `Go` held high continuously: a new run starts on every DONE entry, one cycle later.

## Test plan
1. NPROG=3; `Ack` model raises `Ack` at RUN cycles 5, 10 and 7 → `CycleVld` strobes with (`ProgIdx`,`CycleCt`) = (0,5), (1,10), (2,7). `Done`=1 one cycle after the third strobe, `Timeout`=0, and exactly three `Start` pulses.
2. `Ack` held high through LAUNCH and RUN cycle 1, dropped, then raised at cycle 4 → no strobe before cycle 4 and `CycleCt`=4. With `Ack` held constantly high, `CycleCt`=2 for every program.
3. TIMEOUT=20, `Ack` never asserted → the cycle after RUN cycle 20 has `CycleVld`=1, `CycleCt`=20, `ProgIdx`=0, `Timeout`=1 and `Done`=1; no further `Start`.
4. `Go` pulsed during RUN → ignored, `ProgIdx` sequence unchanged. `Go` in DONE after a timeout → `Timeout` and `Done` clear and `ProgIdx`=0 with `Start` on the next cycle.
5. `Reset` driven low mid-RUN of program 1, asynchronously off an edge → all outputs read 0 before the next `Clk` edge. After release, `Go` restarts at `ProgIdx`=0.
6. NPROG=1 with `Ack` at cycle 3 → one strobe with (0,3), then DONE directly, and `ProgIdx` stays 0.
